vend_session_ctrl: RTL and testbench
====================================

Name: vend_session_ctrl

Overview:
- Transaction sequencer in front of the vending_machine datapath: accumulates coin credit, collects the two-key selection (row A-D, column 1-4) and fetches the price over a request/ack handshake.
- On sufficient credit it sequences the dispense mechanism, then pays change one coin at a time.
- Handles cancel, invalid selection and inactivity timeout; a timeout with credit refunds the credit.

Parameters:
- TIMEOUT_CYCLES, 1000, idle cycles before timeout; range 2..65535.
- CREDIT_MAX, 1000, max credit in cents; a coin exceeding it is rejected.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low; all state cleared while low
- coin_valid  in  1  one-cycle pulse, coin accepted by mech
- coin_value  in  16  coin value in cents, valid with coin_valid
- key_row  in  4  one-hot pulse, bit0=A..bit3=D
- key_col  in  4  one-hot pulse, bit0=1..bit3=4
- cancel  in  1  one-cycle pulse, refund request
- price_req  out  1  price lookup request
- price_sel  out  4  selection index = row*4+col (A1=0, D4=15)
- price_ack  in  1  lookup done; price_data valid this cycle
- price_data  in  16  price in cents; 0 = sold out/unassigned
- vend_req  out  1  dispense request
- vend_sel  out  4  selection being dispensed
- vend_done  in  1  dispense complete
- pay_req  out  1  eject one coin
- pay_coin  out  2  0=100c, 1=25c, 2=5c
- pay_ack  in  1  coin ejected
- credit  out  16  current credit, cents
- price_shown  out  16  last looked-up price
- success  out  1  one-cycle pulse on vend_done
- error  out  1  one-cycle pulse: invalid key sequence or price 0
- coin_reject  out  1  one-cycle pulse: coin refused

Behaviour:
- All outputs registered. Reset value of every output is 0; state returns to IDLE, timer and latched row cleared.
- States: IDLE, HAVE_ROW, LOOKUP, CHECK, VEND, PAYOUT.
- Coins:
  - Accepted only in IDLE/HAVE_ROW; credit += coin_value next cycle.
  - A coin is refused (coin_reject=1, credit unchanged) if credit+coin_value > CREDIT_MAX, and in all other states.
- IDLE:
  - key_row -> latch row, go to HAVE_ROW.
  - key_col alone -> error pulse.
  - cancel with credit>0 -> PAYOUT; cancel with credit==0 is ignored.
- HAVE_ROW:
  - key_col -> price_sel=row*4+col, go to LOOKUP.
  - key_row (e.g. AA) -> error pulse, row cleared, IDLE.
  - cancel -> PAYOUT if credit>0, else IDLE.
- Non-one-hot key vectors -> error pulse, no state change except HAVE_ROW->IDLE.
- Same-cycle priorities: cancel beats key; key_row beats key_col; a coin in the same cycle as a key is processed as well.
- LOOKUP:
  - price_req asserted the cycle after entry; held with stable price_sel until price_ack.
  - On ack, latch price_shown=price_data and go to CHECK. price_data==0 -> error pulse, IDLE.
- CHECK (1 cycle):
  - credit >= price -> credit -= price, go to VEND.
  - Otherwise go to IDLE; price_shown held, credit kept, selection cleared.
- VEND:
  - vend_req with vend_sel held until vend_done.
  - Then success pulse. Go to PAYOUT if credit>0, else IDLE.
- PAYOUT:
  - pay_coin = largest coin <= credit; pay_req held until pay_ack, then credit -= coin value.
  - pay_req drops for one cycle between coins.
  - When credit < 5, the residue is cleared and the block goes to IDLE.
- Handshakes: price_ack, vend_done and pay_ack are ignored unless the matching request is high.
- Timeout:
  - Counter runs in IDLE/HAVE_ROW; cleared by any coin, key or cancel, and on every state change.
  - At TIMEOUT_CYCLES-1: credit>0 -> PAYOUT; else row cleared, IDLE.
  - A coin arriving in the timeout cycle wins (counter restarts).
- Reset low mid-transaction: requests drop asynchronously; credit is lost (power-loss refund is handled by the coin mech).

Optional Feature:
- Macro: VEND_MULTI_VEND_EN.
- Defined: after VEND with credit>0, return to IDLE keeping credit for a further selection; cancel or timeout pays it out.
- Undefined: remaining credit is paid out immediately after every vend.

Test Plan:
- Coins 25,25,25,25; keys A,2; price_data=100 -> vend_sel=1, success pulse, credit=0, no pay_req, IDLE.
- Coins 100,100; keys A,3; price 150 -> vend_sel=2, success, then pay_coin=1 twice, credit=0.
- Coins 25,50,50,75 (credit 200); keys A,A -> error, IDLE; then key 4 -> error; then keys A,4 with price 175 -> vend_sel=3, one 25c payout.
- Coins 100,100; keys B,1; price 250 -> no vend_req, price_shown=250, credit=200, IDLE.
- Coin 100, no activity for TIMEOUT_CYCLES -> PAYOUT, pay_coin=0 once, credit=0; a coin in the timeout cycle delays this.
- Coin 100, reset low mid-LOOKUP -> all outputs 0 asynchronously; coin 1000 with credit 100 -> coin_reject.

Source files
------------

// File: rtl/vend_session_ctrl_if.sv
// Handshake bundle between the session sequencer and the price table, dispenser and coin hopper.
// Each channel is a level request held until a one-cycle ack/done from the slave.
interface vend_session_ctrl_if;
  logic        price_req;
  logic [3:0]  price_sel;
  logic        price_ack;
  logic [15:0] price_data;
  logic        vend_req;
  logic [3:0]  vend_sel;
  logic        vend_done;
  logic        pay_req;
  logic [1:0]  pay_coin;
  logic        pay_ack;

  modport master (
    output price_req, price_sel, vend_req, vend_sel, pay_req, pay_coin,
    input  price_ack, price_data, vend_done, pay_ack
  );

  modport slave (
    input  price_req, price_sel, vend_req, vend_sel, pay_req, pay_coin,
    output price_ack, price_data, vend_done, pay_ack
  );
endinterface

// File: rtl/vend_session_ctrl.sv
// Vending session sequencer: coin credit, two-key selection, price lookup, dispense, change payout.
// Define VEND_MULTI_VEND_EN to keep leftover credit after a vend; all outputs registered, requests held until ack.
module vend_session_ctrl #(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int CREDIT_MAX     = 1000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                coin_valid,
  input  logic [15:0]         coin_value,
  input  logic [3:0]          key_row,
  input  logic [3:0]          key_col,
  input  logic                cancel,
  vend_session_ctrl_if.master hs,
  output logic [15:0]         credit,
  output logic [15:0]         price_shown,
  output logic                success,
  output logic                error,
  output logic                coin_reject
);

  typedef enum logic [2:0] {IDLE, HAVE_ROW, LOOKUP, CHECK, VEND, PAYOUT} state_t;

  state_t      state_q, state_d;
  logic [1:0]  row_q, row_d;
  logic [15:0] timer_q, timer_d;

  logic [15:0] credit_d, price_shown_d;
  logic [3:0]  price_sel_d, vend_sel_d;
  logic [1:0]  pay_coin_d;
  logic        price_req_d, vend_req_d, pay_req_d;
  logic        success_d, error_d, coin_reject_d;

  logic        in_entry, coin_ok, activity, timeout_hit, timeout_now;
  logic [16:0] coin_sum;
  logic [15:0] credit_acc;

  function automatic logic one_hot(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  function automatic logic [1:0] key_idx(input logic [3:0] v);
    if (v[3]) return 2'd3;
    if (v[2]) return 2'd2;
    if (v[1]) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [15:0] coin_cents(input logic [1:0] c);
    case (c)
      2'd0:    return 16'd100;
      2'd1:    return 16'd25;
      2'd2:    return 16'd5;
      default: return 16'd0;
    endcase
  endfunction

  assign in_entry    = (state_q == IDLE) || (state_q == HAVE_ROW);
  assign coin_sum    = {1'b0, credit} + {1'b0, coin_value};
  assign coin_ok     = coin_valid && in_entry && (coin_sum <= 17'(CREDIT_MAX));
  assign credit_acc  = coin_ok ? coin_sum[15:0] : credit;
  assign activity    = coin_valid || (key_row != 4'd0) || (key_col != 4'd0) || cancel;
  assign timeout_hit = (timer_q == 16'(TIMEOUT_CYCLES - 1));
  // Any user activity in the timeout cycle wins over the timeout.
  assign timeout_now = timeout_hit && !activity;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      row_q   <= 2'd0;
      timer_q <= 16'd0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    case (state_q)
      IDLE: begin
        if (cancel) begin
          if (credit_acc != 16'd0) state_d = PAYOUT;
        end else if (key_row != 4'd0) begin
          if (one_hot(key_row)) begin
            state_d = HAVE_ROW;
            row_d   = key_idx(key_row);
          end
        end else if (timeout_now && credit != 16'd0) begin
          state_d = PAYOUT;
        end
      end
      HAVE_ROW: begin
        if (cancel)                 state_d = (credit_acc != 16'd0) ? PAYOUT : IDLE;
        else if (key_row != 4'd0)   state_d = IDLE;
        else if (key_col != 4'd0)   state_d = one_hot(key_col) ? LOOKUP : IDLE;
        else if (timeout_now)       state_d = (credit != 16'd0) ? PAYOUT : IDLE;
      end
      LOOKUP: begin
        if (hs.price_req && hs.price_ack) state_d = (hs.price_data == 16'd0) ? IDLE : CHECK;
      end
      CHECK: state_d = (credit >= price_shown) ? VEND : IDLE;
      VEND: begin
        if (hs.vend_req && hs.vend_done) begin
`ifdef VEND_MULTI_VEND_EN
          state_d = IDLE;
`else
          state_d = (credit != 16'd0) ? PAYOUT : IDLE;
`endif
        end
      end
      PAYOUT: begin
        if (!hs.pay_req && credit < 16'd5) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (state_d != HAVE_ROW) row_d = 2'd0;

    if ((state_d != state_q) || activity || timeout_hit || !in_entry) timer_d = 16'd0;
    else                                                             timer_d = timer_q + 16'd1;
  end

  always_comb begin
    credit_d      = credit_acc;
    price_shown_d = price_shown;
    price_sel_d   = hs.price_sel;
    vend_sel_d    = hs.vend_sel;
    pay_coin_d    = hs.pay_coin;
    price_req_d   = 1'b0;
    vend_req_d    = 1'b0;
    pay_req_d     = 1'b0;
    success_d     = 1'b0;
    error_d       = 1'b0;
    coin_reject_d = coin_valid && !coin_ok;
    case (state_q)
      IDLE: begin
        if (!cancel) error_d = (key_row != 4'd0) ? !one_hot(key_row) : (key_col != 4'd0);
      end
      HAVE_ROW: begin
        if (!cancel) begin
          if (key_row != 4'd0) begin
            error_d = 1'b1;
          end else if (key_col != 4'd0) begin
            if (one_hot(key_col)) price_sel_d = {row_q, key_idx(key_col)};
            else                  error_d     = 1'b1;
          end
        end
      end
      LOOKUP: begin
        // Request rises the cycle after entry and drops with the accepted ack.
        price_req_d = !(hs.price_req && hs.price_ack);
        if (hs.price_req && hs.price_ack) begin
          price_shown_d = hs.price_data;
          error_d       = (hs.price_data == 16'd0);
        end
      end
      CHECK: begin
        if (credit >= price_shown) begin
          credit_d   = credit - price_shown;
          vend_req_d = 1'b1;
          vend_sel_d = hs.price_sel;
        end
      end
      VEND: begin
        vend_req_d = hs.vend_req && !hs.vend_done;
        success_d  = hs.vend_req && hs.vend_done;
      end
      PAYOUT: begin
        if (hs.pay_req) begin
          pay_req_d = !hs.pay_ack;
          if (hs.pay_ack) credit_d = credit - coin_cents(hs.pay_coin);
        end else if (credit < 16'd5) begin
          credit_d = 16'd0;
        end else begin
          pay_req_d  = 1'b1;
          pay_coin_d = (credit >= 16'd100) ? 2'd0 : (credit >= 16'd25) ? 2'd1 : 2'd2;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      credit       <= 16'd0;
      price_shown  <= 16'd0;
      hs.price_sel <= 4'd0;
      hs.vend_sel  <= 4'd0;
      hs.pay_coin  <= 2'd0;
      hs.price_req <= 1'b0;
      hs.vend_req  <= 1'b0;
      hs.pay_req   <= 1'b0;
      success      <= 1'b0;
      error        <= 1'b0;
      coin_reject  <= 1'b0;
    end else begin
      credit       <= credit_d;
      price_shown  <= price_shown_d;
      hs.price_sel <= price_sel_d;
      hs.vend_sel  <= vend_sel_d;
      hs.pay_coin  <= pay_coin_d;
      hs.price_req <= price_req_d;
      hs.vend_req  <= vend_req_d;
      hs.pay_req   <= pay_req_d;
      success      <= success_d;
      error        <= error_d;
      coin_reject  <= coin_reject_d;
    end
  end

endmodule

// File: tb/tb_vend_session_ctrl.sv
// Bench for vend_session_ctrl: directed session table, corner-case sequences and random sessions
// compared against a coin-arithmetic model of a whole purchase.
module tb_vend_session_ctrl;
  localparam int TO   = 64;
  localparam int CMAX = 1000;
`ifdef VEND_MULTI_VEND_EN
  localparam int MULTI = 1;
`else
  localparam int MULTI = 0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        coin_valid;
  logic [15:0] coin_value;
  logic [3:0]  key_row, key_col;
  logic        cancel;
  logic [15:0] credit, price_shown;
  logic        success, error, coin_reject;

  vend_session_ctrl_if bus();

  vend_session_ctrl #(.TIMEOUT_CYCLES(TO), .CREDIT_MAX(CMAX)) dut (
    .clk(clk), .reset(reset),
    .coin_valid(coin_valid), .coin_value(coin_value),
    .key_row(key_row), .key_col(key_col), .cancel(cancel),
    .hs(bus.master),
    .credit(credit), .price_shown(price_shown),
    .success(success), .error(error), .coin_reject(coin_reject)
  );

  always #5 clk = ~clk;

  typedef struct {
    int c0, c1, c2, c3;
    int row, col, price;
    int exp_vend, exp_err, exp_sel, exp_rem;
    int n100, n25, n5;
  } rec_t;

  int n_chk = 0, n_bad = 0, cur = 0;
  int price_resp = 0;
  logic hold_price = 1'b0;

  // Slave-side responder and event log; only this process writes the c_* counters.
  int c_vend = 0, c_succ = 0, c_err = 0, c_rej = 0, c_p100 = 0, c_p25 = 0, c_p5 = 0;
  logic [3:0] last_sel = 4'd0;
  int pd = 0, pc = 0, vd = 0, vc = 0, yd = 0, yc = 0;

  initial begin
    bus.price_ack = 1'b0; bus.price_data = 16'd0; bus.vend_done = 1'b0; bus.pay_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (success)     c_succ++;
      if (error)       c_err++;
      if (coin_reject) c_rej++;
      if (bus.price_ack) bus.price_ack = 1'b0;
      else if (bus.price_req && !hold_price) begin
        if (pc >= pd) begin
          bus.price_ack = 1'b1; bus.price_data = 16'(price_resp);
          pc = 0; pd = $urandom_range(0, 3);
        end else pc++;
      end else pc = 0;
      if (bus.vend_done) bus.vend_done = 1'b0;
      else if (bus.vend_req) begin
        if (vc >= vd) begin
          bus.vend_done = 1'b1; c_vend++; last_sel = bus.vend_sel;
          vc = 0; vd = $urandom_range(0, 3);
        end else vc++;
      end else vc = 0;
      if (bus.pay_ack) bus.pay_ack = 1'b0;
      else if (bus.pay_req) begin
        if (yc >= yd) begin
          bus.pay_ack = 1'b1;
          case (bus.pay_coin)
            2'd0:    c_p100++;
            2'd1:    c_p25++;
            2'd2:    c_p5++;
            default: ;
          endcase
          yc = 0; yd = $urandom_range(0, 3);
        end else yc++;
      end else yc = 0;
    end
  end

  task automatic check(input string name, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s (case %0d): got %0d, expected %0d", name, cur, got, exp);
    end
  endtask

  task automatic pulse_coin(input int v);
    @(negedge clk); coin_valid = 1'b1; coin_value = 16'(v);
    @(negedge clk); coin_valid = 1'b0; coin_value = 16'd0;
  endtask

  task automatic press(input logic [3:0] r, input logic [3:0] c);
    @(negedge clk); key_row = r; key_col = c;
    @(negedge clk); key_row = 4'd0; key_col = 4'd0;
  endtask

  task automatic press_cancel();
    @(negedge clk); cancel = 1'b1;
    @(negedge clk); cancel = 1'b0;
  endtask

  task automatic wait_quiet();
    int q = 0;
    int b = 0;
    while (q < 8 && b < 600) begin
      @(negedge clk); b++;
      if (bus.price_req || bus.vend_req || bus.pay_req) q = 0;
      else q++;
    end
    n_chk++;
    if (q < 8) begin
      n_bad++;
      $display("FAIL wait_quiet (case %0d): handshakes still busy after %0d cycles", cur, b);
    end
  endtask

  function automatic rec_t model(input rec_t t);
    rec_t r = t;
    int sum = t.c0 + t.c1 + t.c2 + t.c3;
    r.exp_sel  = t.row * 4 + t.col;
    r.exp_err  = (t.price == 0) ? 1 : 0;
    r.exp_vend = (t.price != 0 && sum >= t.price) ? 1 : 0;
    r.exp_rem  = (r.exp_vend != 0) ? sum - t.price : sum;
    r.n100     = r.exp_rem / 100;
    r.n25      = (r.exp_rem % 100) / 25;
    r.n5       = (r.exp_rem % 25) / 5;
    return r;
  endfunction

  function automatic int pick_coin();
    case ($urandom_range(0, 3))
      0:       return 5;
      1:       return 25;
      2:       return 50;
      default: return 100;
    endcase
  endfunction

  task automatic apply(input rec_t t);
    int v0 = c_vend, s0 = c_succ, e0 = c_err, r0 = c_rej;
    int a0 = c_p100, b0 = c_p25, f0 = c_p5;
    int cs[4];
    cs[0] = t.c0; cs[1] = t.c1; cs[2] = t.c2; cs[3] = t.c3;
    price_resp = t.price;
    for (int i = 0; i < 4; i++)
      if (cs[i] != 0) begin pulse_coin(cs[i]); @(negedge clk); end
    press(4'(1 << t.row), 4'd0);
    @(negedge clk);
    press(4'd0, 4'(1 << t.col));
    wait_quiet();
    check("price_sel", bus.price_sel, t.exp_sel);
    check("price_shown", price_shown, t.price);
    check("credit_after_check", credit, (t.exp_vend != 0 && MULTI == 0) ? 0 : t.exp_rem);
    press_cancel();
    wait_quiet();
    check("vend_count", c_vend - v0, t.exp_vend);
    check("success_count", c_succ - s0, t.exp_vend);
    if (t.exp_vend != 0) check("vend_sel", last_sel, t.exp_sel);
    check("error_count", c_err - e0, t.exp_err);
    check("reject_count", c_rej - r0, 0);
    check("paid_100", c_p100 - a0, t.n100);
    check("paid_25", c_p25 - b0, t.n25);
    check("paid_5", c_p5 - f0, t.n5);
    check("credit_final", credit, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog");
  end

  initial begin
    rec_t tbl[8];
    int e0, v0, a0, b0, p0, r0;
    tbl[0] = '{25, 25, 25, 25, 0, 1, 100, 1, 0, 1, 0, 0, 0, 0};
    tbl[1] = '{100, 100, 0, 0, 0, 2, 150, 1, 0, 2, 50, 0, 2, 0};
    tbl[2] = '{100, 100, 0, 0, 1, 0, 250, 0, 0, 4, 200, 2, 0, 0};
    tbl[3] = '{50, 0, 0, 0, 2, 3, 0, 0, 1, 11, 50, 0, 2, 0};
    tbl[4] = '{100, 100, 100, 5, 3, 3, 215, 1, 0, 15, 90, 0, 3, 3};
    tbl[5] = '{1000, 0, 0, 0, 0, 0, 5, 1, 0, 0, 995, 9, 3, 4};
    tbl[6] = '{25, 25, 5, 0, 1, 2, 55, 1, 0, 6, 0, 0, 0, 0};
    tbl[7] = '{5, 0, 0, 0, 3, 0, 10, 0, 0, 12, 5, 0, 0, 1};

    reset = 1'b0; coin_valid = 1'b0; coin_value = 16'd0;
    key_row = 4'd0; key_col = 4'd0; cancel = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outs", {bus.price_req, bus.vend_req, bus.pay_req, success, error, coin_reject,
                         bus.pay_coin, bus.price_sel, bus.vend_sel}, 0);
    check("reset_credit", credit, 0);
    check("reset_price_shown", price_shown, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      cur = i;
      apply(tbl[i]);
    end

    // Bad key sequences, then a good selection with one quarter of change.
    cur = 50;
    e0 = c_err; v0 = c_vend; b0 = c_p25;
    pulse_coin(25); pulse_coin(50); pulse_coin(50); pulse_coin(75);
    @(negedge clk);
    check("credit_200", credit, 200);
    press(4'b0001, 4'd0); press(4'b0001, 4'd0); @(negedge clk);
    check("err_AA", c_err - e0, 1);
    press(4'd0, 4'b1000); @(negedge clk);
    check("err_col_alone", c_err - e0, 2);
    press(4'b0011, 4'd0); @(negedge clk);
    check("err_not_onehot", c_err - e0, 3);
    price_resp = 175;
    press(4'b0001, 4'd0); press(4'd0, 4'b1000);
    wait_quiet();
    press_cancel();
    wait_quiet();
    check("A4_vend_count", c_vend - v0, 1);
    check("A4_vend_sel", last_sel, 3);
    check("A4_paid_25", c_p25 - b0, 1);
    check("A4_credit", credit, 0);
    check("A4_err_total", c_err - e0, 3);

    // Inactivity timeout, with a coin landing exactly in the timeout cycle.
    cur = 60;
    a0 = c_p100; p0 = c_p100 + c_p25 + c_p5;
    pulse_coin(100);
    repeat (TO - 2) @(negedge clk);
    check("to_no_early_pay", c_p100 + c_p25 + c_p5 - p0, 0);
    check("to_credit_held", credit, 100);
    pulse_coin(100);
    check("to_coin_wins", credit, 200);
    check("to_no_pay_yet", bus.pay_req, 0);
    repeat (TO - 1) @(negedge clk);
    check("to_pay_req_before", bus.pay_req, 0);
    check("to_credit_before", credit, 200);
    repeat (2) @(negedge clk);
    check("to_pay_req_after", bus.pay_req, 1);
    check("to_pay_coin", bus.pay_coin, 0);
    wait_quiet();
    check("to_paid_100", c_p100 - a0, 2);
    check("to_credit_final", credit, 0);

    for (int i = 0; i < 24; i++) begin
      rec_t r;
      int n;
      n = $urandom_range(1, 4);
      r.c0 = pick_coin();
      r.c1 = (n > 1) ? pick_coin() : 0;
      r.c2 = (n > 2) ? pick_coin() : 0;
      r.c3 = (n > 3) ? pick_coin() : 0;
      r.row = $urandom_range(0, 3);
      r.col = $urandom_range(0, 3);
      r.price = (i % 6 == 5) ? 0 : 5 * $urandom_range(1, 80);
      cur = 100 + i;
      apply(model(r));
    end

    // Reset dropped while a price lookup is outstanding.
    cur = 70;
    hold_price = 1'b1;
    price_resp = 50;
    pulse_coin(100);
    press(4'b0001, 4'd0); press(4'd0, 4'b0001);
    for (int b = 0; b < 20 && !bus.price_req; b++) @(negedge clk);
    check("lookup_req_high", bus.price_req, 1);
    #2 reset = 1'b0;
    #1;
    check("async_reset_outs", {bus.price_req, bus.vend_req, bus.pay_req, success, error, coin_reject,
                               bus.pay_coin, bus.price_sel, bus.vend_sel}, 0);
    check("async_reset_credit", credit, 0);
    check("async_reset_price_shown", price_shown, 0);
    @(negedge clk);
    reset = 1'b1;
    hold_price = 1'b0;
    r0 = c_rej;
    pulse_coin(100); @(negedge clk);
    check("post_reset_credit", credit, 100);
    pulse_coin(1000); @(negedge clk);
    check("reject_over_max", c_rej - r0, 1);
    check("reject_credit_kept", credit, 100);
    press_cancel();
    wait_quiet();
    check("post_reset_refund", credit, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_chk, n_bad);
    $finish;
  end
endmodule
